// File: rtl/mcu_tx_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mcu_tx_arbiter_pkg
// Description : Shared definitions for the MCU UART transmit arbiter:
//               arbiter state encoding, requester slot indices and the
//               frame delimiter codes used by the frame generators.
// Revision    : 1.0 - initial release
// ============================================================================
package mcu_tx_arbiter_pkg;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Requester slot assignment on the shared transmitter
  localparam int REQ_ENQUIRE = 0;  // parameter enquire reply
  localparam int REQ_SET_ACK = 1;  // parameter-set acknowledge
  localparam int REQ_UPLOAD  = 2;  // wave data upload

  // Frame delimiter codes
  localparam logic [7:0] FRAME_HEAD = 8'h68;
  localparam logic [7:0] FRAME_TAIL = 8'h16;

endpackage
`default_nettype wire

// File: rtl/mcu_tx_arbiter_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mcu_tx_arbiter_rr_pick
// Description : Combinational round-robin selector. Returns a one-hot pick
//               of the first asserted request, searching upward from the
//               slot after the last grant and wrapping at N.
// Ports       : req  - request vector (N)
//               last - index of the most recently granted requester
//               pick - one-hot selection, zero when req is zero
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_tx_arbiter_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     pick
);

  int   w_idx;
  logic w_found;

  always_comb begin
    pick    = '0;
    w_found = 1'b0;
    w_idx   = 0;
    // Offsets 1..N visit every slot once, the last granted slot last.
    for (int k = 1; k <= N; k++) begin
      w_idx = int'(last) + k;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      if (!w_found && req[w_idx[IDX_W-1:0]]) begin
        pick[w_idx[IDX_W-1:0]] = 1'b1;
        w_found                = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mcu_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mcu_tx_arbiter
// Description : Shares one UART transmitter among N frame generators.
//               Whole frames are granted round-robin; the owner's bytes and
//               start pulses are forwarded, idle status is returned only to
//               the owner, a guard gap of idle cycles separates frames and
//               a watchdog forces release of a stuck owner.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               req            - per-requester frame run flag (N)
//               req_tx_data    - requester bytes, byte i at [8i+7:8i]
//               req_start_tx   - per-requester byte start pulse (N)
//               req_tx_idle    - idle status returned to requesters (N)
//               grant          - one-hot current owner (N)
//               uart_tx_data   - byte to the UART
//               uart_start_tx  - byte start pulse to the UART
//               uart_tx_idle   - UART idle status
//               timeout_err    - one-cycle pulse on forced release
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_tx_arbiter
  import mcu_tx_arbiter_pkg::*;
#(
  parameter int N           = 3,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int GUARD_CYC   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_tx_data,
  input  logic [N-1:0]   req_start_tx,
  output logic [N-1:0]   req_tx_idle,
  output logic [N-1:0]   grant,
  output logic [7:0]     uart_tx_data,
  output logic           uart_start_tx,
  input  logic           uart_tx_idle,
  output logic           timeout_err
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GRD_W = $clog2(GUARD_CYC + 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_last;        // last granted slot, also the current owner
  logic [N-1:0]     r_pend;
  logic [7:0]       r_pend_data [N];
  logic [TMR_W-1:0] r_timer;
  logic [GRD_W-1:0] r_guard;

  logic [7:0]       w_req_byte [N];
  logic [N-1:0]     w_pick;
  logic [IDX_W-1:0] w_pick_idx;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign w_req_byte[i] = req_tx_data[8*i +: 8];
  end

  mcu_tx_arbiter_rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req  (req),
    .last (r_last),
    .pick (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick[i]) begin
        w_pick_idx = IDX_W'(i);
      end
    end
  end

  // Only the owner sees the UART go busy; everyone else reads idle.
  assign req_tx_idle = ~(grant & {N{~uart_tx_idle}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_last        <= IDX_W'(N - 1);
      r_pend        <= '0;
      r_timer       <= '0;
      r_guard       <= '0;
      grant         <= '0;
      uart_tx_data  <= '0;
      uart_start_tx <= 1'b0;
      timeout_err   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_pend_data[i] <= '0;
      end
    end else begin
      uart_start_tx <= 1'b0;
      timeout_err   <= 1'b0;

      // Non-owners: hold one early byte, forget it if the frame is abandoned.
      for (int i = 0; i < N; i++) begin
        if (!grant[i]) begin
          if (req[i] && req_start_tx[i]) begin
            r_pend[i]      <= 1'b1;
            r_pend_data[i] <= w_req_byte[i];
          end else if (!req[i]) begin
            r_pend[i] <= 1'b0;
          end
        end
      end

      case (r_state)
        IDLE: begin
          r_guard <= '0;
          if (|req) begin
            grant   <= w_pick;
            r_last  <= w_pick_idx;
            r_timer <= '0;
            r_state <= GRANT;
          end
        end

        GRANT: begin
          r_timer <= r_timer + 1'b1;
          // A held byte goes out first; a live pulse colliding with it is
          // queued behind it so byte order is kept.
          if (r_pend[r_last]) begin
            uart_tx_data  <= r_pend_data[r_last];
            uart_start_tx <= 1'b1;
            if (req_start_tx[r_last]) begin
              r_pend_data[r_last] <= w_req_byte[r_last];
            end else begin
              r_pend[r_last] <= 1'b0;
            end
          end else if (req_start_tx[r_last]) begin
            uart_tx_data  <= w_req_byte[r_last];
            uart_start_tx <= 1'b1;
          end

          if (r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            timeout_err    <= 1'b1;
            r_pend[r_last] <= 1'b0;
            grant          <= '0;
            r_guard        <= '0;
            r_state        <= DRAIN;
          end else if (!req[r_last]) begin
            grant   <= '0;
            r_guard <= '0;
            r_state <= DRAIN;
          end
        end

        DRAIN: begin
          if (!uart_tx_idle) begin
            r_guard <= '0;
          end else if (r_guard == GRD_W'(GUARD_CYC - 1)) begin
            r_guard <= '0;
            r_state <= IDLE;
          end else begin
            r_guard <= r_guard + 1'b1;
          end
        end

        default: begin
          grant   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcu_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mcu_tx_arbiter
// Description : Directed self-checking bench for mcu_tx_arbiter. A second
//               instance with a short watchdog covers forced release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_tx_arbiter;
  import mcu_tx_arbiter_pkg::*;

  localparam int GUARD = 16;
  localparam int BUSY  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  req_start_tx;
  logic [23:0] req_tx_data;
  logic        uart_tx_idle;

  logic [2:0]  req_tx_idle, grant;
  logic [7:0]  uart_tx_data;
  logic        uart_start_tx, timeout_err;

  logic [2:0]  t_req_tx_idle, t_grant;
  logic [7:0]  t_uart_tx_data;
  logic        t_uart_start_tx, t_timeout_err;

  int errors = 0;
  int checks = 0;

  // UART model and transmit log (driven from the main instance)
  int         busy_cnt = 0;
  int         sent_cnt = 0;
  logic [7:0] sent_log [256];

  bit         idle_mon_en = 1'b0;
  int         idle_viol   = 0;
  bit         gchk_en     = 1'b0;
  logic [2:0] exp_grant   = 3'b000;
  int         grant_viol  = 0;

  logic [7:0] frame  [10] = '{FRAME_HEAD, 8'h11, 8'h22, 8'h33, 8'h44,
                              8'h55, 8'h66, 8'h77, 8'h88, FRAME_TAIL};
  logic [2:0] rr_exp [4]  = '{3'b001, 3'b010, 3'b100, 3'b001};

  always #5 clk = ~clk;

  assign uart_tx_idle = (busy_cnt == 0);

  always @(posedge clk) begin
    if (uart_start_tx) begin
      busy_cnt <= BUSY;
      sent_log[sent_cnt[7:0]] <= uart_tx_data;
      sent_cnt <= sent_cnt + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  mcu_tx_arbiter #(.N(3), .TIMEOUT_CYC(1000), .GUARD_CYC(GUARD)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_tx_data   (req_tx_data),
    .req_start_tx  (req_start_tx),
    .req_tx_idle   (req_tx_idle),
    .grant         (grant),
    .uart_tx_data  (uart_tx_data),
    .uart_start_tx (uart_start_tx),
    .uart_tx_idle  (uart_tx_idle),
    .timeout_err   (timeout_err)
  );

  mcu_tx_arbiter #(.N(3), .TIMEOUT_CYC(100), .GUARD_CYC(GUARD)) dut_to (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_tx_data   (req_tx_data),
    .req_start_tx  (req_start_tx),
    .req_tx_idle   (t_req_tx_idle),
    .grant         (t_grant),
    .uart_tx_data  (t_uart_tx_data),
    .uart_start_tx (t_uart_start_tx),
    .uart_tx_idle  (uart_tx_idle),
    .timeout_err   (t_timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (idle_mon_en && ((req_tx_idle | grant) !== 3'b111)) idle_viol++;
    if (gchk_en && (grant !== exp_grant)) grant_viol++;
  endtask

  task automatic do_reset();
    int n;
    req = '0; req_start_tx = '0; req_tx_data = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n = 0;
    while (!uart_tx_idle && n < 40) begin tick(); n++; end
  endtask

  task automatic wait_grant(input int idx);
    int n = 0;
    while (grant[idx] !== 1'b1 && n < 100) begin tick(); n++; end
    if (grant[idx] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_grant[%0d]: grant=%b, required bit %0d set", idx, grant, idx);
    end
  endtask

  task automatic wait_byte_done(input int idx);
    int n = 0;
    while (req_tx_idle[idx] !== 1'b0 && n < 40) begin tick(); n++; end
    if (req_tx_idle[idx] !== 1'b0) begin
      checks++; errors++;
      $display("FAIL idle_fall[%0d]: idle=%b, required 0", idx, req_tx_idle[idx]);
    end
    n = 0;
    while (req_tx_idle[idx] !== 1'b1 && n < 60) begin tick(); n++; end
    if (req_tx_idle[idx] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL idle_rise[%0d]: idle=%b, required 1", idx, req_tx_idle[idx]);
    end
  endtask

  task automatic send_byte(input int idx, input logic [7:0] b);
    req_tx_data[8*idx +: 8] = b;
    req_start_tx[idx] = 1'b1;
    tick();
    req_start_tx[idx] = 1'b0;
    wait_byte_done(idx);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rst_grant: got %b, required 000", grant); end
    checks++; if (uart_start_tx !== 1'b0) begin errors++; $display("FAIL rst_start: got %b, required 0", uart_start_tx); end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", uart_tx_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b, required 0", timeout_err); end
    checks++; if (req_tx_idle !== 3'b111) begin errors++; $display("FAIL rst_idle: got %b, required 111", req_tx_idle); end
  endtask

  task automatic test_single_frame();
    int base, n;
    do_reset();
    base = sent_cnt;
    req[REQ_ENQUIRE] = 1'b1;
    wait_grant(REQ_ENQUIRE);
    exp_grant = 3'b001; grant_viol = 0; gchk_en = 1'b1;
    for (int b = 0; b < 10; b++) send_byte(REQ_ENQUIRE, frame[b]);
    gchk_en = 1'b0;
    req[REQ_ENQUIRE] = 1'b0;
    tick();
    checks++; if (sent_cnt - base !== 10) begin errors++; $display("FAIL frame_count: got %0d, required 10", sent_cnt - base); end
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (sent_log[(base + b) % 256] !== frame[b]) begin
        errors++; $display("FAIL frame_byte%0d: got %h, required %h", b, sent_log[(base + b) % 256], frame[b]);
      end
    end
    checks++; if (grant_viol !== 0) begin errors++; $display("FAIL frame_grant_hold: %0d cycles off, required 0", grant_viol); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL frame_release: got %b, required 000", grant); end
    // Guard gap: GUARD drain cycles plus one arbitration cycle.
    req[REQ_SET_ACK] = 1'b1;
    n = 0;
    while (grant === 3'b000 && n < 60) begin tick(); n++; end
    checks++; if (n !== GUARD + 1) begin errors++; $display("FAIL guard_gap: got %0d cycles, required %0d", n, GUARD + 1); end
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL guard_next: got %b, required 010", grant); end
    req = '0;
  endtask

  task automatic test_pend_same_cycle();
    int base;
    do_reset();
    base = sent_cnt;
    req[REQ_SET_ACK] = 1'b1;
    req_tx_data[15:8] = 8'hA5;
    req_start_tx[REQ_SET_ACK] = 1'b1;
    tick();
    req_start_tx = '0;
    req_tx_data[15:8] = 8'h00;
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL pend_grant: got %b, required 010", grant); end
    checks++; if (uart_start_tx !== 1'b0) begin errors++; $display("FAIL pend_early: got %b, required 0", uart_start_tx); end
    tick();
    checks++;
    if (uart_start_tx !== 1'b1 || uart_tx_data !== 8'hA5) begin
      errors++; $display("FAIL pend_issue: start=%b data=%h, required 1/a5", uart_start_tx, uart_tx_data);
    end
    wait_byte_done(REQ_SET_ACK);
    send_byte(REQ_SET_ACK, 8'h5A);
    checks++;
    if (sent_cnt - base !== 2 || sent_log[(base + 1) % 256] !== 8'h5A) begin
      errors++; $display("FAIL pend_follow: count=%0d byte=%h, required 2/5a", sent_cnt - base, sent_log[(base + 1) % 256]);
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    int base, n, o;
    do_reset();
    base = sent_cnt;
    idle_viol = 0; idle_mon_en = 1'b1;
    req = 3'b111;
    for (int f = 0; f < 4; f++) begin
      n = 0;
      while (grant === 3'b000 && n < 100) begin tick(); n++; end
      checks++; if (grant !== rr_exp[f]) begin errors++; $display("FAIL rr_order%0d: got %b, required %b", f, grant, rr_exp[f]); end
      o = -1;
      for (int k = 0; k < 3; k++) if (grant[k] === 1'b1) o = k;
      if (o < 0) break;
      for (int b = 0; b < 3; b++) send_byte(o, 8'(16 * o + b));
      req[o] = 1'b0;
      tick();
      req[o] = 1'b1;
    end
    idle_mon_en = 1'b0;
    req = '0;
    checks++; if (idle_viol !== 0) begin errors++; $display("FAIL rr_nonowner_idle: %0d bad cycles, required 0", idle_viol); end
    checks++; if (sent_cnt - base !== 12) begin errors++; $display("FAIL rr_count: got %0d, required 12", sent_cnt - base); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req[REQ_UPLOAD] = 1'b1;
    n = 0;
    while (t_grant === 3'b000 && n < 50) begin tick(); n++; end
    checks++; if (t_grant !== 3'b100) begin errors++; $display("FAIL to_grant: got %b, required 100", t_grant); end
    n = 0;
    while (t_timeout_err !== 1'b1 && n < 200) begin tick(); n++; end
    checks++; if (n !== 100) begin errors++; $display("FAIL to_cycle: got %0d, required 100", n); end
    checks++; if (t_grant !== 3'b000) begin errors++; $display("FAIL to_release: got %b, required 000", t_grant); end
    req[REQ_ENQUIRE] = 1'b1;
    tick();
    checks++; if (t_timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b, required 0", t_timeout_err); end
    n = 0;
    while (t_grant === 3'b000 && n < 100) begin tick(); n++; end
    checks++; if (t_grant !== 3'b001) begin errors++; $display("FAIL to_next: got %b, required 001", t_grant); end
    req = '0;
  endtask

  task automatic test_nonowner_drop();
    int base, hits;
    do_reset();
    base = sent_cnt;
    req[REQ_ENQUIRE] = 1'b1;
    wait_grant(REQ_ENQUIRE);
    req[REQ_UPLOAD] = 1'b1;
    req_tx_data[23:16] = 8'h55;
    req_start_tx[REQ_UPLOAD] = 1'b1;
    tick();
    req_start_tx = '0;
    checks++; if (dut.r_pend[2] !== 1'b1) begin errors++; $display("FAIL drop_capture: pend=%b, required 1", dut.r_pend[2]); end
    req[REQ_UPLOAD] = 1'b0;
    tick();
    checks++; if (dut.r_pend[2] !== 1'b0) begin errors++; $display("FAIL drop_clear: pend=%b, required 0", dut.r_pend[2]); end
    send_byte(REQ_ENQUIRE, 8'h33);
    req[REQ_ENQUIRE] = 1'b0;
    for (int k = 0; k < 25; k++) tick();
    hits = 0;
    for (int k = base; k < sent_cnt; k++) if (sent_log[k % 256] === 8'h55) hits++;
    checks++; if (hits !== 0 || sent_cnt - base !== 1) begin
      errors++; $display("FAIL drop_no_forward: 0x55 seen %0d times, count %0d, required 0/1", hits, sent_cnt - base);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    do_reset();
    req[REQ_ENQUIRE] = 1'b1;
    wait_grant(REQ_ENQUIRE);
    for (int b = 0; b < 3; b++) send_byte(REQ_ENQUIRE, frame[b]);
    req_tx_data[7:0] = frame[3];
    req_start_tx[REQ_ENQUIRE] = 1'b1;
    tick();
    req_start_tx = '0;
    n = 0;
    while (req_tx_idle[0] !== 1'b0 && n < 40) begin tick(); n++; end
    rst = 1'b1;
    tick();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL mid_rst_grant: got %b, required 000", grant); end
    checks++; if (uart_start_tx !== 1'b0) begin errors++; $display("FAIL mid_rst_start: got %b, required 0", uart_start_tx); end
    checks++; if (req_tx_idle !== 3'b111) begin errors++; $display("FAIL mid_rst_idle: got %b, required 111", req_tx_idle); end
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d, required %0d", dut.r_state, IDLE); end
    rst = 1'b0;
    req = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; req_start_tx = '0; req_tx_data = '0;
    test_reset();
    test_single_frame();
    test_pend_same_cycle();
    test_round_robin();
    test_timeout();
    test_nonowner_drop();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mcu_tx_arbiter.md
Name: mcu_tx_arbiter

Overview:
- Shares the single MCU UART transmitter among N frame-generating modules (parameter enquire reply, parameter-set acknowledge, wave data upload).
- Each requester holds its run flag high for one whole frame. The arbiter grants whole frames round-robin and forwards the granted requester's bytes and start pulses to the UART.
- It routes the UART idle status back to the granted requester only.
- It enforces an inter-frame guard gap and a watchdog against a requester that never releases.

Parameters:
- N, 3, number of requesters (2..8).
- TIMEOUT_CYC, 50000000, maximum cycles a grant may be held before forced release.
- GUARD_CYC, 16, consecutive cycles uart_tx_idle must be high before the next grant.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  N  per-requester run flag; high for the duration of one frame.
- req_tx_data  in  8*N  byte of requester i in bits [8i+7:8i]; valid in the cycle of its start pulse.
- req_start_tx  in  N  one-cycle byte start pulse per requester.
- req_tx_idle  out  N  idle status returned to each requester.
- grant  out  N  one-hot current owner; all zero when no requester owns the UART.
- uart_tx_data  out  8  byte to the UART transmitter.
- uart_start_tx  out  1  one-cycle start pulse to the UART.
- uart_tx_idle  in  1  UART idle; low while a byte shifts out.
- timeout_err  out  1  one-cycle pulse on a forced release.

Behaviour:
- Reset values: grant=0, uart_tx_data=0, uart_start_tx=0, timeout_err=0, req_tx_idle=all ones, state=IDLE, last=N-1, pend=0, timer=0. All outputs are registered except req_tx_idle.
- req_tx_idle[i] = uart_tx_idle when grant[i], else 1. Non-owners therefore see no falling edge.
- IDLE:
  - If req≠0, grant the first requester with req high, searching from last+1 upward with wrap.
  - grant is set in the next cycle; state becomes GRANT; last is updated; timer is cleared.
- Pending capture:
  - A req_start_tx[i] arriving while grant[i]=0 and req[i]=1 sets pend[i] and stores pend_data[i]=req_tx_data[i].
  - Only one pending byte is kept per requester; a second pulse overwrites it.
  - This covers a requester pulsing start in the same cycle its run flag rises.
- GRANT, owner g:
  - If pend[g] is set: in the first GRANT cycle, uart_tx_data<=pend_data[g], uart_start_tx<=1, and pend[g] is cleared.
  - A req_start_tx[g] pulse gives uart_tx_data<=req_tx_data[g] and uart_start_tx<=1 one cycle later (latency 1).
  - Start pulses from non-owners are only captured into pend. They are never forwarded.
  - timer increments every cycle.
  - req[g]=0 → go to DRAIN.
  - timer==TIMEOUT_CYC-1 → pulse timeout_err, clear pend[g], go to DRAIN.
  - If req[g] falls in the same cycle as a start pulse, the byte is still forwarded, then the state goes to DRAIN.
- DRAIN:
  - grant is cleared on entry.
  - Count consecutive cycles with uart_tx_idle=1; any 0 restarts the count.
  - When the count reaches GUARD_CYC, go to IDLE.
  - Result: the UART is idle at the next grant, so the new owner never sees a spurious falling edge.
- A requester whose req drops while ungranted and pending has pend[i] cleared.
- rst asserted mid-frame returns everything to reset values in the next cycle. Any byte in flight in the UART is not tracked.
- Round-robin is fair: with all req held high, grants cycle 0,1,..,N-1,0.

Decomposition:
- Shared package/include: state encodings (IDLE, GRANT, DRAIN) and the requester index constants REQ_ENQUIRE=0, REQ_SET_ACK=1, REQ_UPLOAD=2, alongside the existing frame code defines.
- Sub-module rr_pick: combinational round-robin selector with inputs req and last, output one-hot pick.

Test Plan:
- Requester 0 only sends a 10-byte frame (0x68 … 0x16), with uart_tx_idle low for 20 cycles per byte → 10 uart_start_tx pulses, bytes identical and in order, grant=001 throughout. grant=000 GUARD_CYC idle cycles after req[0] falls.
- req[1] rises with req_start_tx[1] in the same cycle, data 0xA5 → pend captured; first GRANT cycle issues uart_start_tx with 0xA5; no byte lost.
- req=111 held, each frame 3 bytes → grant order 001,010,100,001. Non-owner req_tx_idle stays 1 throughout.
- Requester 2 holds req forever, with TIMEOUT_CYC=100 → timeout_err pulses at cycle 100 of the grant; grant released; requester 0 is granted next.
- Non-owner pulses req_start_tx[2] with 0x55 then drops req[2] before being granted → no uart_start_tx carries 0x55; pend[2]=0.
- rst asserted during byte 4 of a frame → next cycle grant=0, uart_start_tx=0, req_tx_idle=all ones, state IDLE.
